// File: rtl/apb_master_ctrl.sv
// APB3 master: turns one core load/store request into an APB SETUP/ACCESS transfer,
// decodes NUM_SLV 4 KB slave windows and ends each transfer with a one-cycle ready pulse.
module apb_master_ctrl #(
  parameter int unsigned NUM_SLV   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   transfer,
  input  logic                   write,
  input  logic [31:0]            addr,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic                   ready,
  output logic                   busErr,
  output logic [31:0]            PADDR,
  output logic                   PWRITE,
  output logic [31:0]            PWDATA,
  output logic                   PENABLE,
  output logic [NUM_SLV-1:0]     PSEL,
  input  logic [NUM_SLV*32-1:0]  PRDATA,
  input  logic [NUM_SLV-1:0]     PREADY,
  input  logic [NUM_SLV-1:0]     PSLVERR
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        paddr_q, paddr_d;
  logic [31:0]        pwdata_q, pwdata_d;
  logic               pwrite_q, pwrite_d;
  logic               penable_q, penable_d;
  logic [NUM_SLV-1:0] psel_q, psel_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               mapped_q, mapped_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [19:0]        dec_off;
  logic               dec_mapped;
  logic [IDX_W-1:0]   dec_idx;
  logic [NUM_SLV-1:0] dec_onehot;

  logic [31:0]        sel_rdata;
  logic               sel_ready;
  logic               sel_err;
  logic               timeout_c;
  logic               done_c;
  logic               err_c;
  logic [31:0]        rdata_c;

  // Window decode; addresses below BASE_ADDR would wrap the 20-bit offset, hence the extra compare
  always_comb begin
    dec_off    = addr[31:12] - BASE_ADDR[31:12];
    dec_mapped = (addr >= BASE_ADDR) && (dec_off < 20'(NUM_SLV));
    dec_idx    = dec_off[IDX_W-1:0];
    dec_onehot = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      dec_onehot[i] = (dec_idx == IDX_W'(i));
    end
  end

  // Response mux from the selected slave only
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_rdata = PRDATA[32*i +: 32];
        sel_ready = PREADY[i];
        sel_err   = PSLVERR[i];
      end
    end
    timeout_c = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
  end

  // Completion: unmapped first, then slave PREADY, then timeout
  always_comb begin
    done_c  = 1'b0;
    err_c   = 1'b0;
    rdata_c = '0;
    if (state_q == ACCESS) begin
      if (!mapped_q) begin
        done_c = 1'b1;
        err_c  = 1'b1;
      end else if (sel_ready) begin
        done_c  = 1'b1;
        err_c   = sel_err;
        rdata_c = pwrite_q ? 32'h0 : sel_rdata;
      end else if (timeout_c) begin
        done_c = 1'b1;
        err_c  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    penable_d = penable_q;
    psel_d    = psel_q;
    idx_d     = idx_q;
    mapped_d  = mapped_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (transfer) begin
          paddr_d  = addr;
          pwdata_d = wdata;
          pwrite_d = write;
          idx_d    = dec_idx;
          mapped_d = dec_mapped;
          psel_d   = dec_mapped ? dec_onehot : '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (done_c) begin
          psel_d    = '0;
          penable_d = 1'b0;
          cnt_d     = '0;
          state_d   = IDLE;
        end else if (TIMEOUT != 0) begin
          // Stops at TIMEOUT-1 because the transfer completes there, so it never wraps
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        psel_d    = '0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      penable_q <= 1'b0;
      psel_q    <= '0;
      idx_q     <= '0;
      mapped_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      penable_q <= penable_d;
      psel_q    <= psel_d;
      idx_q     <= idx_d;
      mapped_q  <= mapped_d;
      cnt_q     <= cnt_d;
    end
  end

  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign PWRITE  = pwrite_q;
  assign PENABLE = penable_q;
  assign PSEL    = psel_q;
  assign ready   = done_c;
  assign busErr  = err_c;
  assign rdata   = rdata_c;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Scoreboard bench for apb_master_ctrl: configurable APB slave models, per-cycle protocol
// checks against a queue of expected transfers.
module tb_apb_master_ctrl;

  localparam int unsigned NS   = 4;
  localparam int unsigned TMO  = 8;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          transfer;
  logic          write;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          ready;
  logic          busErr;
  logic [31:0]   PADDR;
  logic          PWRITE;
  logic [31:0]   PWDATA;
  logic          PENABLE;
  logic [NS-1:0] PSEL;
  logic [NS*32-1:0] prdata;
  logic [NS-1:0] pready;
  logic [NS-1:0] pslverr;

  apb_master_ctrl #(.NUM_SLV(NS), .BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .transfer(transfer), .write(write), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .busErr(busErr), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PENABLE(PENABLE), .PSEL(PSEL), .PRDATA(prdata), .PREADY(pready),
    .PSLVERR(pslverr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int mon_off;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Slave models; unselected slaves drive junk to show it is ignored
  int          wait_cfg[NS];
  bit          hang[NS];
  bit          err_cfg[NS];
  logic [31:0] data_cfg[NS];
  int          acc_cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) acc_cnt <= 0;
    else if (PENABLE) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  always_comb begin
    for (int i = 0; i < NS; i++) begin
      pready[i]  = PSEL[i] ? (PENABLE && !hang[i] && acc_cnt >= wait_cfg[i]) : 1'b1;
      pslverr[i] = PSEL[i] ? err_cfg[i] : 1'b1;
      prdata[32*i +: 32] = PSEL[i] ? data_cfg[i] : (32'hBAD0_0000 | 32'(i));
    end
  end

  typedef struct {
    int          start;
    int          lat;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        wr;
    logic        err;
    logic [3:0]  psel;
  } exp_t;

  exp_t sb_q[$];

  // Per-cycle monitor for the transfer at the head of the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (sb_q.size() > 0) begin
        mon_off = cyc - sb_q[0].start;
        check("psel", 32'(PSEL), (mon_off == 0) ? 32'h0 : 32'(sb_q[0].psel));
        check("penable", 32'(PENABLE), 32'(mon_off >= 2));
        if (mon_off >= 1) begin
          check("paddr", PADDR, sb_q[0].addr);
          check("pwrite", 32'(PWRITE), 32'(sb_q[0].wr));
          check("pwdata", PWDATA, sb_q[0].wdata);
        end
        check("ready_cycle", 32'(ready), 32'(mon_off == sb_q[0].lat));
        if (ready) begin
          check("rdata", rdata, sb_q[0].rdata);
          check("busErr", 32'(busErr), 32'(sb_q[0].err));
          void'(sb_q.pop_front());
        end
      end else if (ready) begin
        check("spurious_ready", 32'(ready), 32'h0);
      end
    end
  end

  task automatic do_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d, input bit keep);
    exp_t e;
    int   s;
    bit   mapped;
    bit   got;
    mapped = (a >= BASE) && (a < BASE + 32'h0000_4000);
    s      = mapped ? int'((a - BASE) >> 12) : 0;
    e.addr  = a;
    e.wdata = d;
    e.wr    = wr;
    e.psel  = mapped ? 4'(1 << s) : 4'b0000;
    if (!mapped) begin
      e.lat = 2; e.err = 1'b1; e.rdata = 32'h0;
    end else if (hang[s] || wait_cfg[s] >= int'(TMO)) begin
      e.lat = 2 + int'(TMO) - 1; e.err = 1'b1; e.rdata = 32'h0;
    end else begin
      e.lat = 2 + wait_cfg[s]; e.err = err_cfg[s]; e.rdata = wr ? 32'h0 : data_cfg[s];
    end
    @(posedge clk); #1;
    transfer = 1'b1; write = wr; addr = a; wdata = d;
    e.start = cyc;
    sb_q.push_back(e);
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (ready) got = 1'b1;
    end
    if (!got) begin
      check("xfer_no_ready", 32'h0, 32'h1);
      sb_q.delete();
    end
    if (!keep) begin
      @(posedge clk); #1;
      transfer = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit got;
    rst = 1'b0; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    for (int i = 0; i < NS; i++) begin
      wait_cfg[i] = 0; hang[i] = 1'b0; err_cfg[i] = 1'b0;
      data_cfg[i] = 32'hC0DE_0000 + 32'(i);
    end
    #12;
    check("rst_psel", 32'(PSEL), 32'h0);
    check("rst_penable", 32'(PENABLE), 32'h0);
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_paddr", PADDR, 32'h0);
    check("rst_pwdata", PWDATA, 32'h0);
    check("rst_pwrite", 32'(PWRITE), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_buserr", 32'(busErr), 32'h0);
    #10 rst = 1'b1;

    // Zero-wait write to slave 1
    do_xfer(1'b1, 32'h1000_1004, 32'hDEAD_BEEF, 1'b0);

    // Read from slave 3 with two wait states
    wait_cfg[3] = 2; data_cfg[3] = 32'h1234_5678;
    do_xfer(1'b0, 32'h1000_3008, 32'h0, 1'b0);

    // Unmapped: just past the last window and just below the first
    do_xfer(1'b0, 32'h1000_4000, 32'h0, 1'b0);
    do_xfer(1'b0, 32'h0FFF_FFFC, 32'h0, 1'b0);

    // Timeout on slave 0, then idle bus the following cycle
    hang[0] = 1'b1;
    do_xfer(1'b0, 32'h1000_0000, 32'h0, 1'b0);
    @(negedge clk);
    check("tmo_idle_psel", 32'(PSEL), 32'h0);
    check("tmo_idle_penable", 32'(PENABLE), 32'h0);

    // PREADY in the last allowed ACCESS cycle beats the timeout
    hang[0] = 1'b0; wait_cfg[0] = int'(TMO) - 1; data_cfg[0] = 32'h5A5A_0F0F;
    do_xfer(1'b0, 32'h1000_0FFC, 32'h0, 1'b0);

    // Slave error write followed back-to-back by a clean read
    wait_cfg[0] = 0; err_cfg[2] = 1'b1;
    do_xfer(1'b1, 32'h1000_2010, 32'hCAFE_F00D, 1'b1);
    do_xfer(1'b0, 32'h1000_0040, 32'h0, 1'b0);
    err_cfg[2] = 1'b0;

    // Random traffic over the mapped windows
    for (int k = 0; k < 8; k++) begin
      int s;
      s = int'($urandom_range(0, NS - 1));
      wait_cfg[s] = int'($urandom_range(0, 3));
      err_cfg[s]  = 1'($urandom_range(0, 1));
      data_cfg[s] = $urandom;
      do_xfer(1'($urandom_range(0, 1)), BASE + 32'(s) * 32'h1000 + (32'($urandom_range(0, 1023)) << 2),
              $urandom, 1'b0);
    end

    // Reset while waiting on PREADY from slave 1
    hang[1] = 1'b1;
    @(posedge clk); #1;
    transfer = 1'b1; write = 1'b0; addr = 32'h1000_1010; wdata = '0;
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (PENABLE) got = 1'b1;
    end
    check("rst_test_access", 32'(got), 32'h1);
    repeat (2) @(negedge clk);
    check("pre_rst_psel", 32'(PSEL), 32'h2);
    #2;
    rst = 1'b0; transfer = 1'b0;
    #1;
    check("async_rst_psel", 32'(PSEL), 32'h0);
    check("async_rst_penable", 32'(PENABLE), 32'h0);
    check("async_rst_ready", 32'(ready), 32'h0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    hang[1] = 1'b0; wait_cfg[1] = 1; data_cfg[1] = 32'h0BAD_CAFE;
    do_xfer(1'b0, 32'h1000_1010, 32'h0, 1'b0);

    repeat (3) @(posedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
